// File: rtl/nibble_sched.sv
// nibble_sched: round-robin, credit-limited issue of requester bundles onto one nibble_top
// datapath; results are tagged with the requester index and queued in a FIFO.
module nibble_sched #(
    parameter int NREQ        = 4,
    parameter int IDW         = 2,
    parameter int PIPE_LAT    = 3,
    parameter int OFIFO_DEPTH = 4
) (
    input  logic              CLK,
    input  logic              RESET,
    input  logic [NREQ-1:0]   REQ_VALID,
    output logic [NREQ-1:0]   REQ_READY,
    input  logic [NREQ*32-1:0] REQ_DATA_A,
    input  logic [NREQ*32-1:0] REQ_DATA_B,
    input  logic [NREQ*12-1:0] REQ_SEL_A,
    input  logic [NREQ*12-1:0] REQ_SEL_B,
    input  logic [NREQ*4-1:0]  REQ_SEL_AB,
    output logic [31:0]       DP_DATA_A,
    output logic [31:0]       DP_DATA_B,
    output logic [11:0]       DP_SEL_A,
    output logic [11:0]       DP_SEL_B,
    output logic [3:0]        DP_SEL_AB,
    output logic              DP_RESET_L,
    input  logic [3:0]        DP_DATA_OUT,
    output logic              RES_VALID,
    input  logic              RES_READY,
    output logic [3:0]        RES_NIBBLE,
    output logic [IDW-1:0]    RES_ID,
    input  logic              FLUSH,
    output logic              FLUSH_DONE,
    output logic              BUSY
);
    localparam int PW = $clog2(OFIFO_DEPTH);
    localparam int CW = $clog2(OFIFO_DEPTH + 1);
    localparam int SW = $clog2(PIPE_LAT + OFIFO_DEPTH + 2);

    typedef enum logic [1:0] {RUN, DRAIN, DONE} state_t;

    state_t                      r_state, w_next;
    logic [IDW-1:0]              r_rr, w_gidx;
    logic                        w_any, w_accept, w_can_issue, w_push, w_pop, w_busy;
    logic [PIPE_LAT:0]           r_tv;
    logic [PIPE_LAT:0][IDW-1:0]  r_tid;
    logic [IDW+3:0]              r_mem [OFIFO_DEPTH];
    logic [PW-1:0]               r_wp, r_rp;
    logic [CW-1:0]               r_cnt;
    logic [SW-1:0]               w_inflight;
    logic                        r_flush_done;

    function automatic logic [PW-1:0] ptr_inc(input logic [PW-1:0] p);
        return (p == PW'(OFIFO_DEPTH - 1)) ? '0 : p + 1'b1;
    endfunction

    assign w_inflight  = SW'($countones(r_tv));
    assign w_busy      = (w_inflight != '0) || (r_cnt != '0);
    // Outstanding work includes results already queued; a pop this cycle is not credited.
    assign w_can_issue = (r_state == RUN) && (w_inflight + SW'(r_cnt) < SW'(OFIFO_DEPTH));
    assign w_push      = r_tv[PIPE_LAT];
    assign w_pop       = RES_VALID && RES_READY;

    always_comb begin
        int c;
        w_any  = 1'b0;
        w_gidx = '0;
        for (int k = 0; k < NREQ; k++) begin
            c = int'(r_rr) + k;
            c = (c >= NREQ) ? c - NREQ : c;
            if (!w_any && REQ_VALID[IDW'(c)]) begin
                w_any  = 1'b1;
                w_gidx = IDW'(c);
            end
        end
    end

    assign w_accept  = w_can_issue && w_any && !RESET;
    assign REQ_READY = w_accept ? (NREQ'(1) << w_gidx) : '0;

    always_ff @(posedge CLK) begin
        if (RESET) begin
            DP_DATA_A <= '0;
            DP_DATA_B <= '0;
            DP_SEL_A  <= '0;
            DP_SEL_B  <= '0;
            DP_SEL_AB <= '0;
            r_rr      <= '0;
            r_tv      <= '0;
            r_tid     <= '0;
        end else begin
            if (w_accept) begin
                DP_DATA_A <= REQ_DATA_A[32*int'(w_gidx) +: 32];
                DP_DATA_B <= REQ_DATA_B[32*int'(w_gidx) +: 32];
                DP_SEL_A  <= REQ_SEL_A[12*int'(w_gidx) +: 12];
                DP_SEL_B  <= REQ_SEL_B[12*int'(w_gidx) +: 12];
                DP_SEL_AB <= REQ_SEL_AB[4*int'(w_gidx) +: 4];
                r_rr      <= (w_gidx == IDW'(NREQ - 1)) ? '0 : w_gidx + 1'b1;
            end
            r_tv  <= {r_tv[PIPE_LAT-1:0], w_accept};
            r_tid <= {r_tid[PIPE_LAT-1:0], w_gidx};
        end
    end

    always_ff @(posedge CLK) begin
        if (w_push)
            r_mem[r_wp] <= {DP_DATA_OUT, r_tid[PIPE_LAT]};
    end

    always_ff @(posedge CLK) begin
        if (RESET) begin
            r_wp  <= '0;
            r_rp  <= '0;
            r_cnt <= '0;
        end else begin
            r_wp  <= w_push ? ptr_inc(r_wp) : r_wp;
            r_rp  <= w_pop ? ptr_inc(r_rp) : r_rp;
            r_cnt <= r_cnt + CW'(w_push) - CW'(w_pop);
        end
    end

    always_comb begin
        w_next = r_state;
        case (r_state)
            RUN:     w_next = FLUSH ? DRAIN : RUN;
            DRAIN:   w_next = !FLUSH ? RUN : (w_busy ? DRAIN : DONE);
            DONE:    w_next = FLUSH ? DONE : RUN;
            default: w_next = RUN;
        endcase
    end

    always_ff @(posedge CLK) begin
        if (RESET) begin
            r_state      <= RUN;
            r_flush_done <= 1'b0;
        end else begin
            r_state      <= w_next;
            r_flush_done <= (w_next == DONE);
        end
    end

    assign {RES_NIBBLE, RES_ID} = r_mem[r_rp];
    assign RES_VALID  = (r_cnt != '0);
    assign FLUSH_DONE = r_flush_done;
    assign BUSY       = w_busy;
    assign DP_RESET_L = ~RESET;
endmodule

// File: tb/tb_nibble_sched.sv
// tb_nibble_sched: directed and random checks of nibble_sched against a stand-in
// 3-cycle nibble datapath and a scoreboard of expected {nibble,id} results.
module tb_nibble_sched;
    localparam int NREQ = 4, IDW = 2, DEPTH = 4;

    logic CLK = 1'b0;
    logic RESET = 1'b1;
    always #5 CLK = ~CLK;

    logic [NREQ-1:0]    REQ_VALID, REQ_READY;
    logic [31:0]        a [NREQ], b [NREQ];
    logic [11:0]        sa [NREQ], sb [NREQ];
    logic [3:0]         sab [NREQ];
    logic [NREQ*32-1:0] req_a, req_b;
    logic [NREQ*12-1:0] req_sa, req_sb;
    logic [NREQ*4-1:0]  req_sab;
    logic [31:0]        DP_DATA_A, DP_DATA_B;
    logic [11:0]        DP_SEL_A, DP_SEL_B;
    logic [3:0]         DP_SEL_AB, DP_DATA_OUT, RES_NIBBLE;
    logic               DP_RESET_L, RES_VALID, RES_READY, FLUSH, FLUSH_DONE, BUSY;
    logic [IDW-1:0]     RES_ID;
    logic [3:0]         dp1, dp2, dp3;

    always_comb begin
        for (int i = 0; i < NREQ; i++) begin
            req_a[32*i +: 32]  = a[i];
            req_b[32*i +: 32]  = b[i];
            req_sa[12*i +: 12] = sa[i];
            req_sb[12*i +: 12] = sb[i];
            req_sab[4*i +: 4]  = sab[i];
        end
    end

    nibble_sched dut (
        .CLK(CLK), .RESET(RESET), .REQ_VALID(REQ_VALID), .REQ_READY(REQ_READY),
        .REQ_DATA_A(req_a), .REQ_DATA_B(req_b), .REQ_SEL_A(req_sa), .REQ_SEL_B(req_sb),
        .REQ_SEL_AB(req_sab), .DP_DATA_A(DP_DATA_A), .DP_DATA_B(DP_DATA_B),
        .DP_SEL_A(DP_SEL_A), .DP_SEL_B(DP_SEL_B), .DP_SEL_AB(DP_SEL_AB),
        .DP_RESET_L(DP_RESET_L), .DP_DATA_OUT(DP_DATA_OUT), .RES_VALID(RES_VALID),
        .RES_READY(RES_READY), .RES_NIBBLE(RES_NIBBLE), .RES_ID(RES_ID),
        .FLUSH(FLUSH), .FLUSH_DONE(FLUSH_DONE), .BUSY(BUSY)
    );

    // Stand-in datapath: pick one nibble of each operand, combine per SEL_AB.
    function automatic logic [3:0] dp_fn(input logic [31:0] x, input logic [31:0] y,
                                         input logic [11:0] s1, input logic [11:0] s2,
                                         input logic [3:0] s3);
        logic [3:0] na, nb;
        na = 4'(x >> (4 * s1[2:0]));
        nb = 4'(y >> (4 * s2[2:0]));
        case (s3[1:0])
            2'd0:    return na ^ nb;
            2'd1:    return na & nb;
            2'd2:    return na | nb;
            default: return na + nb;
        endcase
    endfunction

    always @(posedge CLK) begin
        dp1 <= DP_RESET_L ? dp_fn(DP_DATA_A, DP_DATA_B, DP_SEL_A, DP_SEL_B, DP_SEL_AB) : 4'h0;
        dp2 <= DP_RESET_L ? dp1 : 4'h0;
        dp3 <= DP_RESET_L ? dp2 : 4'h0;
    end
    assign DP_DATA_OUT = dp3;

    logic [IDW+3:0]  q [$];
    logic [NREQ-1:0] acc_mask;
    int n_chk = 0, n_fail = 0, n_acc = 0, n_pop = 0;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // Observe the handshakes that the next edge will act on, then advance one cycle.
    task automatic cyc();
        logic [IDW+3:0] e;
        #2;
        check("onehot", 64'($countones(REQ_READY) <= 1), 64'd1);
        acc_mask = REQ_READY & REQ_VALID;
        for (int g = 0; g < NREQ; g++)
            if (acc_mask[g]) begin
                q.push_back({dp_fn(a[g], b[g], sa[g], sb[g], sab[g]), IDW'(g)});
                n_acc++;
                check("credit", 64'(q.size() <= DEPTH), 64'd1);
            end
        if (RES_VALID && RES_READY) begin
            n_pop++;
            check("q_nonempty", 64'(q.size() > 0), 64'd1);
            if (q.size() > 0) begin
                e = q.pop_front();
                check("result", 64'({RES_NIBBLE, RES_ID}), 64'(e));
            end
        end
        @(posedge CLK);
        #1;
    endtask

    task automatic do_reset();
        REQ_VALID = '0;
        RES_READY = 1'b0;
        RESET = 1'b1;
        cyc();
        RESET = 1'b0;
        q.delete();
        RES_READY = 1'b1;
        #1;
    endtask

    task automatic drain();
        int i;
        i = 0;
        REQ_VALID = '0;
        RES_READY = 1'b1;
        while ((BUSY || q.size() != 0) && i < 40) begin
            cyc();
            i++;
        end
        check("drain_busy", 64'(BUSY), 64'd0);
        check("drain_q", 64'(q.size()), 64'd0);
    endtask

    initial begin
        int n0, p0, i;
        for (int g = 0; g < NREQ; g++) begin
            a[g] = '0; b[g] = '0; sa[g] = '0; sb[g] = '0; sab[g] = '0;
        end
        acc_mask = '0;
        REQ_VALID = '1;
        RES_READY = 1'b0;
        FLUSH = 1'b0;
        RESET = 1'b1;
        cyc();
        cyc();
        check("rst_ready", 64'(REQ_READY), 64'd0);
        check("rst_dp_a", 64'(DP_DATA_A), 64'd0);
        check("rst_dp_sel_ab", 64'(DP_SEL_AB), 64'd0);
        check("rst_res_valid", 64'(RES_VALID), 64'd0);
        check("rst_flush_done", 64'(FLUSH_DONE), 64'd0);
        check("rst_busy", 64'(BUSY), 64'd0);
        check("rst_dp_reset_l", 64'(DP_RESET_L), 64'd0);
        RESET = 1'b0;
        REQ_VALID = '0;
        RES_READY = 1'b1;
        #1;
        check("dp_reset_l_run", 64'(DP_RESET_L), 64'd1);

        // T1: single op, 4-cycle latency
        a[0] = 32'hFFFF_FFFF;
        REQ_VALID = 4'b0001;
        #1;
        check("t1_ready", 64'(REQ_READY), 64'd1);
        cyc();
        REQ_VALID = '0;
        check("t1_dp_a", 64'(DP_DATA_A), 64'hFFFF_FFFF);
        for (int k = 1; k <= 4; k++) begin
            cyc();
            check("t1_res_valid", 64'(RES_VALID), 64'(k == 4));
        end
        check("t1_nibble", 64'(RES_NIBBLE), 64'hF);
        check("t1_id", 64'(RES_ID), 64'd0);
        drain();

        // T2: round robin; credit stalls the fifth grant for two cycles
        do_reset();
        for (int g = 0; g < NREQ; g++) begin
            a[g] = 32'h7654_3210; b[g] = 32'hFEDC_BA98;
            sa[g] = 12'(g); sb[g] = 12'(3 - g); sab[g] = 4'(g);
        end
        REQ_VALID = '1;
        #1;
        for (int k = 0; k < 4; k++) begin
            check("t2_grant", 64'(REQ_READY), 64'(1 << k));
            cyc();
        end
        check("t2_stall0", 64'(REQ_READY), 64'd0);
        cyc();
        check("t2_stall1", 64'(REQ_READY), 64'd0);
        cyc();
        check("t2_grant_wrap", 64'(REQ_READY), 64'b0001);
        cyc();
        drain();

        // T3: backpressure
        RES_READY = 1'b0;
        REQ_VALID = '1;
        n0 = n_acc;
        repeat (12) cyc();
        check("t3_accepts", 64'(n_acc - n0), 64'd4);
        check("t3_blocked", 64'(REQ_READY), 64'd0);
        check("t3_res_valid", 64'(RES_VALID), 64'd1);
        RES_READY = 1'b1;
        #1;
        check("t3_pop_not_credited", 64'(REQ_READY), 64'd0);
        cyc();
        check("t3_resume", 64'(REQ_READY != 0), 64'd1);
        cyc();
        drain();

        // T4: flush with three ops outstanding
        REQ_VALID = '1;
        repeat (3) cyc();
        REQ_VALID = '0;
        FLUSH = 1'b1;
        cyc();
        REQ_VALID = '1;
        p0 = n_pop;
        i = 0;
        #1;
        while (!FLUSH_DONE && i < 20) begin
            check("t4_no_grant", 64'(REQ_READY), 64'd0);
            cyc();
            i++;
        end
        check("t4_flush_done", 64'(FLUSH_DONE), 64'd1);
        check("t4_pops", 64'(n_pop - p0), 64'd3);
        check("t4_idle", 64'(BUSY), 64'd0);
        FLUSH = 1'b0;
        #1;
        check("t4_done_no_grant", 64'(REQ_READY), 64'd0);
        cyc();
        check("t4_flush_done_low", 64'(FLUSH_DONE), 64'd0);
        check("t4_resume", 64'(REQ_READY != 0), 64'd1);
        cyc();
        drain();

        // T5: reset with two in flight and two queued
        RES_READY = 1'b0;
        REQ_VALID = '1;
        repeat (6) cyc();
        REQ_VALID = '0;
        check("t5_busy_before", 64'(BUSY), 64'd1);
        check("t5_valid_before", 64'(RES_VALID), 64'd1);
        RESET = 1'b1;
        cyc();
        RESET = 1'b0;
        q.delete();
        check("t5_res_valid", 64'(RES_VALID), 64'd0);
        check("t5_busy", 64'(BUSY), 64'd0);
        check("t5_dp_a", 64'(DP_DATA_A), 64'd0);
        check("t5_dp_sel_a", 64'(DP_SEL_A), 64'd0);
        check("t5_dp_sel_ab", 64'(DP_SEL_AB), 64'd0);
        RES_READY = 1'b1;
        repeat (8) begin
            check("t5_no_stale", 64'(RES_VALID), 64'd0);
            cyc();
        end

        // T6: random traffic against the scoreboard
        n0 = n_acc;
        acc_mask = '0;
        i = 0;
        while (n_acc - n0 < 1000 && i < 8000) begin
            for (int g = 0; g < NREQ; g++)
                if (!REQ_VALID[g] || acc_mask[g]) begin
                    a[g] = $urandom; b[g] = $urandom;
                    sa[g] = 12'($urandom); sb[g] = 12'($urandom); sab[g] = 4'($urandom);
                    REQ_VALID[g] = 1'($urandom_range(0, 1));
                end
            RES_READY = ($urandom_range(0, 3) != 0);
            cyc();
            i++;
        end
        check("t6_accepts", 64'(n_acc - n0 >= 1000), 64'd1);
        drain();

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

    initial begin
        #1_000_000;
        $display("FAIL timeout: simulation did not finish");
        $fatal(1);
    end
endmodule
